// File: rtl/uart_tx_fifo_feeder_pkg.sv
// Shared UART timing constants and feeder types.
// The frame-bit count and the bit/frame cycle formulas live here so that the
// feeder, the UART TX and the UART RX all derive their timing the same way.
package uart_tx_fifo_feeder_pkg;

    localparam int DEFAULT_CLK_HZ = 100_000_000;
    localparam int DEFAULT_BAUD   = 9600;

    // Start bit + 8 data bits + 1 stop bit.
    localparam int FRAME_BITS = 10;

    // Clock cycles per UART bit (integer division, truncating).
    function automatic int bitCycles(input int clkHz, input int baud);
        return clkHz / baud;
    endfunction

    // Clock cycles per transmitted frame, including the extra idle guard bits.
    function automatic int frameCycles(input int clkHz, input int baud, input int stopGuard);
        return bitCycles(clkHz, baud) * (FRAME_BITS + stopGuard);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } feederState_e;

endpackage

// File: rtl/uart_tx_fifo_feeder_if.sv
// Byte-push and UART-TX-side signal bundle of the TX FIFO feeder.
// master: the producer/observer of the feeder; slave: the feeder itself.
interface uart_tx_fifo_feeder_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          busy;
    logic          tx_start;
    logic [7:0]    tx_data;

    modport master (
        output wr_en, wr_data,
        input  full, empty, count, overflow, busy, tx_start, tx_data
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, count, overflow, busy, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_fifo_feeder_sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers and registered count/full/empty.
// Writes while full and reads while empty are ignored; contents survive reset.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             push, pop;

    // Qualify the requests and compute next pointer and occupancy values.
    always_comb begin
        push    = wr_en_i && !full_q;
        pop     = rd_en_i && !empty_q;
        wrPtr_d = push ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and status registers; full/empty are registered from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage array, written only on an accepted push and never cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rdPtr_q];
    assign count_o   = count_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/uart_tx_fifo_feeder.sv
// TX FIFO feeder: buffers bytes and paces them into a UART TX that has no
// busy flag, launching one byte per frame time measured by a local counter.
module uart_tx_fifo_feeder
    import uart_tx_fifo_feeder_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int STOP_GUARD = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    uart_tx_fifo_feeder_if.slave    bus
);
    localparam int AW           = $clog2(DEPTH);
    localparam int FRAME_CYCLES = frameCycles(CLK_HZ, BAUD, STOP_GUARD);
    localparam int CW           = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    feederState_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          txStart_q, txStart_d;
    logic [7:0]    txData_q, txData_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic          launch;
    logic          pop;

    logic [7:0]    fifoHead;
    logic [AW:0]   fifoCount;
    logic          fifoFull;
    logic          fifoEmpty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (bus.wr_en),
        .wr_data_i (bus.wr_data),
        .rd_en_i   (pop),
        .rd_data_o (fifoHead),
        .count_o   (fifoCount),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty)
    );

    // Next-state logic: launch a byte from IDLE or at the end of a frame, otherwise count down.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        txStart_d  = 1'b0;
        txData_d   = txData_q;
        busy_d     = busy_q;
        overflow_d = bus.wr_en && fifoFull;
        launch     = 1'b0;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                launch = !fifoEmpty;
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!fifoEmpty) begin
                    launch = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (launch) begin
            pop       = 1'b1;
            txData_d  = fifoHead;
            txStart_d = 1'b1;
            busy_d    = 1'b1;
            cnt_d     = CW'(FRAME_CYCLES - 1);
            state_d   = WAIT;
        end
    end

    // State, frame counter and registered outputs; reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            txStart_q  <= 1'b0;
            txData_q   <= 8'h00;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            txStart_q  <= txStart_d;
            txData_q   <= txData_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.tx_start = txStart_q;
    assign bus.tx_data  = txData_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;
    assign bus.count    = fifoCount;
    assign bus.full     = fifoFull;
    assign bus.empty    = fifoEmpty;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Self-checking bench for uart_tx_fifo_feeder with a small, fast UART timing
// (BIT_CYCLES=4, FRAME_CYCLES=44, DEPTH=4).
module tb_uart_tx_fifo_feeder;

    localparam int FRAME = 44;

    typedef struct {
        logic       we;
        logic [7:0] data;
        logic       accepted;
        logic [2:0] expCount;
        logic       expFull;
        logic       expEmpty;
        logic       expOverflow;
    } vector_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;
    int cycleNum = 0;
    int startCount = 0;
    logic prevStart = 1'b0;
    logic [7:0] expQ [$];
    int startTimes [$];
    vector_t vectors [7];

    uart_tx_fifo_feeder_if #(.AW(2)) bus ();

    uart_tx_fifo_feeder #(
        .DEPTH      (4),
        .CLK_HZ     (1_000_000),
        .BAUD       (250_000),
        .STOP_GUARD (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used to measure the spacing of start strobes.
    always @(posedge clk) cycleNum <= cycleNum + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive inputs, then advance to the next falling edge where outputs are sampled.
    task automatic applyStimulus(input logic we, input logic [7:0] data);
        bus.wr_en   = we;
        bus.wr_data = data;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard monitor: every start strobe must carry the next expected byte.
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            if (prevStart) checkOutput("startTwoCycles", 32'(prevStart), 32'(1'b0));
            startCount++;
            startTimes.push_back(cycleNum);
            if (expQ.size() == 0) checkOutput("spuriousStart", 32'(bus.tx_start), 32'(1'b0));
            else checkOutput("txDataOrder", 32'(bus.tx_data), 32'(expQ.pop_front()));
        end
        prevStart = (bus.tx_start === 1'b1);
    end

    // Hard time limit so the run always ends.
    initial begin
        #200_000;
        $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int busyCycles;
        logic found;
        int startsBefore;

        vectors[0] = '{1'b1, 8'h01, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
        vectors[1] = '{1'b1, 8'h02, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
        vectors[2] = '{1'b1, 8'h03, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
        vectors[3] = '{1'b1, 8'h04, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
        vectors[4] = '{1'b1, 8'h05, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
        vectors[5] = '{1'b1, 8'hFF, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
        vectors[6] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;

        // Reset held with wr_en toggling.
        $display("[TB] reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(i[0] == 1'b0, 8'h77);
            checkOutput("rstTxStart", 32'(bus.tx_start), 32'(1'b0));
            checkOutput("rstTxData", 32'(bus.tx_data), 32'h00);
            checkOutput("rstBusy", 32'(bus.busy), 32'(1'b0));
            checkOutput("rstOverflow", 32'(bus.overflow), 32'(1'b0));
            checkOutput("rstCount", 32'(bus.count), 32'd0);
            checkOutput("rstEmpty", 32'(bus.empty), 32'(1'b1));
            checkOutput("rstFull", 32'(bus.full), 32'(1'b0));
        end
        bus.wr_en = 1'b0;
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00);
        checkOutput("relEmpty", 32'(bus.empty), 32'(1'b1));
        checkOutput("relCount", 32'(bus.count), 32'd0);
        checkOutput("relStarts", 32'(startCount), 32'd0);

        // Single byte: latency, one-cycle strobe, busy width.
        $display("[TB] single byte");
        expQ.push_back(8'hA5);
        applyStimulus(1'b1, 8'hA5);
        checkOutput("t2CountW", 32'(bus.count), 32'd1);
        checkOutput("t2StartW", 32'(bus.tx_start), 32'(1'b0));
        applyStimulus(1'b0, 8'h00);
        checkOutput("t2Start", 32'(bus.tx_start), 32'(1'b1));
        checkOutput("t2Data", 32'(bus.tx_data), 32'hA5);
        checkOutput("t2Busy", 32'(bus.busy), 32'(1'b1));
        checkOutput("t2Empty", 32'(bus.empty), 32'(1'b1));
        busyCycles = 1;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 8'h00);
            if (bus.busy !== 1'b1) break;
            busyCycles++;
            if (bus.tx_start !== 1'b0) checkOutput("t2StartLow", 32'(bus.tx_start), 32'(1'b0));
            if (bus.tx_data !== 8'hA5) checkOutput("t2DataStable", 32'(bus.tx_data), 32'hA5);
        end
        checkOutput("t2BusyCycles", 32'(busyCycles), 32'(FRAME));
        checkOutput("t2IdleBusy", 32'(bus.busy), 32'(1'b0));

        // Burst to full and overflow, table-driven.
        $display("[TB] burst and overflow");
        startTimes.delete();
        for (int i = 0; i < 7; i++) begin
            if (vectors[i].accepted) expQ.push_back(vectors[i].data);
            applyStimulus(vectors[i].we, vectors[i].data);
            checkOutput($sformatf("vecCount%0d", i), 32'(bus.count), 32'(vectors[i].expCount));
            checkOutput($sformatf("vecFull%0d", i), 32'(bus.full), 32'(vectors[i].expFull));
            checkOutput($sformatf("vecEmpty%0d", i), 32'(bus.empty), 32'(vectors[i].expEmpty));
            checkOutput($sformatf("vecOverflow%0d", i), 32'(bus.overflow), 32'(vectors[i].expOverflow));
        end

        // Write at the same edge as a back-to-back pop with two bytes queued.
        $display("[TB] simultaneous write and pop");
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.tx_start === 1'b1 && bus.count === 3'd2) begin
                found = 1'b1;
                break;
            end
            applyStimulus(1'b0, 8'h00);
        end
        checkOutput("t5Locate", 32'(found), 32'(1'b1));
        for (int i = 0; i < FRAME - 1; i++) applyStimulus(1'b0, 8'h00);
        checkOutput("t5PreCount", 32'(bus.count), 32'd2);
        expQ.push_back(8'h55);
        applyStimulus(1'b1, 8'h55);
        checkOutput("t5Count", 32'(bus.count), 32'd2);
        checkOutput("t5Start", 32'(bus.tx_start), 32'(1'b1));
        checkOutput("t5Data", 32'(bus.tx_data), 32'h04);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, 8'h00);
            if (bus.busy !== 1'b1) break;
        end
        checkOutput("t3DrainBusy", 32'(bus.busy), 32'(1'b0));
        checkOutput("t3DrainEmpty", 32'(bus.empty), 32'(1'b1));
        checkOutput("t3QueueLeft", 32'(expQ.size()), 32'd0);
        checkOutput("t3StartNum", 32'(startTimes.size()), 32'd6);
        for (int i = 1; i < startTimes.size(); i++)
            checkOutput($sformatf("t3Gap%0d", i), 32'(startTimes[i] - startTimes[i-1]), 32'(FRAME));

        // Asynchronous reset 20 cycles into a frame with three bytes queued.
        $display("[TB] mid-frame reset");
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(8'hA1 + 8'(i));
            applyStimulus(1'b1, 8'hA1 + 8'(i));
        end
        bus.wr_en = 1'b0;
        checkOutput("t6PreCount", 32'(bus.count), 32'd3);
        for (int i = 0; i < 18; i++) applyStimulus(1'b0, 8'h00);
        checkOutput("t6PreBusy", 32'(bus.busy), 32'(1'b1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6TxStart", 32'(bus.tx_start), 32'(1'b0));
        checkOutput("t6TxData", 32'(bus.tx_data), 32'h00);
        checkOutput("t6Busy", 32'(bus.busy), 32'(1'b0));
        checkOutput("t6Count", 32'(bus.count), 32'd0);
        checkOutput("t6Empty", 32'(bus.empty), 32'(1'b1));
        checkOutput("t6Full", 32'(bus.full), 32'(1'b0));
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        startsBefore = startCount;
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 8'h00);
        checkOutput("t6NoStart", 32'(startCount), 32'(startsBefore));
        checkOutput("t6IdleEmpty", 32'(bus.empty), 32'(1'b1));
        expQ.push_back(8'h5A);
        applyStimulus(1'b1, 8'h5A);
        checkOutput("t6NewCount", 32'(bus.count), 32'd1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("t6NewStart", 32'(bus.tx_start), 32'(1'b1));
        checkOutput("t6NewData", 32'(bus.tx_data), 32'h5A);
        for (int i = 0; i < 50; i++) applyStimulus(1'b0, 8'h00);
        checkOutput("finalQueue", 32'(expQ.size()), 32'd0);
        checkOutput("finalBusy", 32'(bus.busy), 32'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
